// File: rtl/demux3_stage.sv
// One-entry registered 1-to-3 demultiplexer: a producer word is captured with its
// destination select and presented on a shared data bus to exactly one consumer.
module demux3_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_sel,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid_a,
   output logic                  out_valid_b,
   output logic                  out_valid_c,
   input  logic                  out_ready_a,
   input  logic                  out_ready_b,
   input  logic                  out_ready_c,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  err_sel,
   input  logic                  err_clr
);

   // Handshake: a transfer happens on an edge where valid && ready are both high.
   // in_ready depends combinationally on the selected consumer's ready so a word
   // can be replaced in the same cycle it drains (one word per cycle).

   localparam logic [1:0] SEL_A   = 2'b00;
   localparam logic [1:0] SEL_B   = 2'b01;
   localparam logic [1:0] SEL_C   = 2'b10;
   localparam logic [1:0] SEL_BAD = 2'b11;

   logic                  full_q, full_d;
   logic [1:0]            dest_q, dest_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  err_q, err_d;

   logic active;
   logic tgt_ready;
   logic drain;
   logic accept;
   logic accept_legal;
   logic accept_bad;

   assign active = rstn && en;

   always_comb begin
      tgt_ready = 1'b0;
      case (dest_q)
         SEL_A:   tgt_ready = out_ready_a;
         SEL_B:   tgt_ready = out_ready_b;
         SEL_C:   tgt_ready = out_ready_c;
         default: tgt_ready = 1'b0;
      endcase
   end

   assign drain        = active && full_q && tgt_ready;
   assign in_ready     = active && (!full_q || drain);
   assign accept       = in_valid && in_ready;
   assign accept_legal = accept && (in_sel != SEL_BAD);
   assign accept_bad   = accept && (in_sel == SEL_BAD);

   always_comb begin
      full_d = full_q;
      dest_d = dest_q;
      hold_d = hold_q;
      if (accept_legal) begin
         full_d = 1'b1;
         dest_d = in_sel;
         hold_d = in_data;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   // A set in the same cycle as a clear must win so no illegal transfer is lost.
   always_comb begin
      err_d = err_q;
      if (accept_bad) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         full_q <= 1'b0;
         dest_q <= SEL_A;
         hold_q <= '0;
         err_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         dest_q <= dest_d;
         hold_q <= hold_d;
         err_q  <= err_d;
      end
   end

   // Outputs are forced quiet while reset is asserted, even before the reset edge.
   assign out_valid_a = active && full_q && (dest_q == SEL_A);
   assign out_valid_b = active && full_q && (dest_q == SEL_B);
   assign out_valid_c = active && full_q && (dest_q == SEL_C);
   assign out_data    = (rstn && full_q) ? hold_q : '0;
   assign err_sel     = err_q;

endmodule

// File: tb/tb_demux3_stage.sv
// Directed bench for demux3_stage: inputs change just after the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_demux3_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rstn;
   logic         en;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_sel;
   logic [W-1:0] in_data;
   logic         out_valid_a, out_valid_b, out_valid_c;
   logic         out_ready_a, out_ready_b, out_ready_c;
   logic [W-1:0] out_data;
   logic         err_sel;
   logic         err_clr;

   int checks = 0;
   int errors = 0;

   logic [1:0] stream_sel [4];

   demux3_stage #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sel      (in_sel),
      .in_data     (in_data),
      .out_valid_a (out_valid_a),
      .out_valid_b (out_valid_b),
      .out_valid_c (out_valid_c),
      .out_ready_a (out_ready_a),
      .out_ready_b (out_ready_b),
      .out_ready_c (out_ready_c),
      .out_data    (out_data),
      .err_sel     (err_sel),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge (one rising edge has passed).
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [2:0] valids();
      return {out_valid_c, out_valid_b, out_valid_a};
   endfunction

   task automatic idle_inputs();
      in_valid    = 1'b0;
      in_sel      = 2'b00;
      in_data     = '0;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      out_ready_c = 1'b0;
      err_clr     = 1'b0;
      en          = 1'b1;
   endtask

   initial begin
      stream_sel[0] = 2'b00;
      stream_sel[1] = 2'b01;
      stream_sel[2] = 2'b10;
      stream_sel[3] = 2'b00;

      // Reset
      rstn = 1'b0;
      idle_inputs();
      next_cycle();
      next_cycle();
      settle();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_valids", {29'd0, valids()}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err_sel", {31'd0, err_sel}, 32'd0);
      rstn = 1'b1;
      next_cycle();

      // Single transfer to B
      in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hDEADBEEF; out_ready_b = 1'b1;
      settle();
      chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      in_valid = 1'b0;
      settle();
      chk("t1_valids", {29'd0, valids()}, 32'b010);
      chk("t1_data", out_data, 32'hDEADBEEF);
      chk("t1_in_ready_drain", {31'd0, in_ready}, 32'd1);
      next_cycle();
      settle();
      chk("t1_empty_valids", {29'd0, valids()}, 32'd0);
      chk("t1_empty_data", out_data, 32'd0);
      chk("t1_empty_in_ready", {31'd0, in_ready}, 32'd1);

      // Stall on C; a non-target ready must not matter
      idle_inputs();
      in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h11;
      next_cycle();
      in_sel = 2'b00; in_data = 32'h99;
      for (int k = 0; k < 3; k++) begin
         out_ready_a = (k == 1);
         settle();
         chk("stall_valids", {29'd0, valids()}, 32'b100);
         chk("stall_data", out_data, 32'h11);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         next_cycle();
      end
      in_valid = 1'b0; out_ready_a = 1'b0; out_ready_c = 1'b1;
      settle();
      chk("stall_release_valids", {29'd0, valids()}, 32'b100);
      chk("stall_release_data", out_data, 32'h11);
      chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      settle();
      chk("stall_drained", {29'd0, valids()}, 32'd0);

      // Streaming A,B,C,A back to back
      idle_inputs();
      out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_sel = stream_sel[i]; in_data = W'(i + 1);
         settle();
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         if (i > 0) begin
            chk("stream_valids", {29'd0, valids()}, 32'(3'b001 << stream_sel[i-1]));
            chk("stream_data", out_data, W'(i));
         end
         next_cycle();
      end
      in_valid = 1'b0;
      settle();
      chk("stream_last_valids", {29'd0, valids()}, 32'b001);
      chk("stream_last_data", out_data, 32'd4);
      next_cycle();
      settle();
      chk("stream_empty", {29'd0, valids()}, 32'd0);

      // Illegal select
      in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h55;
      settle();
      chk("bad_in_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      in_valid = 1'b0;
      settle();
      chk("bad_valids", {29'd0, valids()}, 32'd0);
      chk("bad_data", out_data, 32'd0);
      chk("bad_err_set", {31'd0, err_sel}, 32'd1);
      in_valid = 1'b1; in_sel = 2'b11; err_clr = 1'b1;
      next_cycle();
      in_valid = 1'b0; err_clr = 1'b0;
      settle();
      chk("bad_set_wins", {31'd0, err_sel}, 32'd1);
      chk("bad_set_wins_valids", {29'd0, valids()}, 32'd0);
      err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      settle();
      chk("bad_clear", {31'd0, err_sel}, 32'd0);

      // Illegal accept while a held word drains empties the stage
      idle_inputs();
      in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hA1;
      next_cycle();
      out_ready_a = 1'b1; in_sel = 2'b11; in_data = 32'hB2;
      settle();
      chk("bad_drain_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bad_drain_data", out_data, 32'hA1);
      next_cycle();
      in_valid = 1'b0;
      settle();
      chk("bad_drain_valids", {29'd0, valids()}, 32'd0);
      chk("bad_drain_data_after", out_data, 32'd0);
      chk("bad_drain_err", {31'd0, err_sel}, 32'd1);

      // Enable freeze with B held; err_clr still honoured
      idle_inputs();
      in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h77;
      next_cycle();
      in_valid = 1'b0; en = 1'b0; out_ready_b = 1'b1;
      for (int k = 0; k < 2; k++) begin
         err_clr = (k == 0);
         settle();
         chk("freeze_valids", {29'd0, valids()}, 32'd0);
         chk("freeze_in_ready", {31'd0, in_ready}, 32'd0);
         chk("freeze_data", out_data, 32'h77);
         next_cycle();
      end
      err_clr = 1'b0;
      settle();
      chk("freeze_err_cleared", {31'd0, err_sel}, 32'd0);
      en = 1'b1;
      settle();
      chk("unfreeze_valids", {29'd0, valids()}, 32'b010);
      chk("unfreeze_data", out_data, 32'h77);
      chk("unfreeze_in_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      settle();
      chk("unfreeze_once", {29'd0, valids()}, 32'd0);

      // Reset mid-operation with A held
      idle_inputs();
      in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hAA;
      next_cycle();
      in_valid = 1'b0;
      settle();
      chk("pre_rst_valids", {29'd0, valids()}, 32'b001);
      rstn = 1'b0;
      settle();
      chk("mid_rst_valids", {29'd0, valids()}, 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      next_cycle();
      rstn = 1'b1; out_ready_a = 1'b1;
      settle();
      chk("post_rst_valids", {29'd0, valids()}, 32'd0);
      chk("post_rst_data", out_data, 32'd0);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
      settle();
      chk("post_rst_no_delivery", {29'd0, valids()}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
